// File: rtl/wb_tg_pkg.sv
// Shared types and constants for the Wishbone burst traffic generator.
package wb_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        WR_GAP,
        RD_BURST,
        RD_GAP,
        DONE
    } tg_state_e;

    typedef enum logic [1:0] {
        MODE_INCR,
        MODE_LFSR,
        MODE_WALK,
        MODE_CHECK
    } tg_mode_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // x^32 + x^22 + x^2 + x^1 + 1 -> feedback from bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic int unsigned burst_beats(input int unsigned words, input int unsigned blen);
        return (words < blen) ? words : blen;
    endfunction

endpackage

// File: rtl/wb_tg_pattern.sv
// Data pattern generator: incrementing address, LFSR, walking one, checkerboard.
module wb_tg_pattern
    import wb_tg_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned APP_AW = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  tg_mode_e          mode,
    input  logic [DW-1:0]     seed,
    input  logic [APP_AW-1:0] addr,
    output logic [DW-1:0]     pattern
);

    logic [31:0]   lfsr;
    logic [DW-1:0] walk;
    logic          chk;
    logic [31:0]   seed_ext;

    assign seed_ext = 32'(seed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 32'd1;
            walk <= DW'(1'b1);
            chk  <= 1'b0;
        end else if (load) begin
            lfsr <= (seed_ext == '0) ? 32'd1 : seed_ext;
            walk <= DW'(1'b1);
            chk  <= 1'b0;
        end else if (advance) begin
            lfsr <= {lfsr[30:0], ^(lfsr & LFSR_TAPS)};
            walk <= {walk[DW-2:0], walk[DW-1]};
            chk  <= ~chk;
        end
    end

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_INCR:  pattern = DW'(addr);
            MODE_LFSR:  pattern = lfsr[DW-1:0];
            MODE_WALK:  pattern = walk;
            MODE_CHECK: pattern = chk ? {(DW/4){4'h5}} : {(DW/4){4'hA}};
            default:    pattern = '0;
        endcase
    end

endmodule

// File: rtl/wb_burst_traffic_gen.sv
// Wishbone B4 burst master: writes a pattern region, reads it back and counts mismatches.
module wb_burst_traffic_gen
    import wb_tg_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned APP_AW    = 26,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [DW-1:0]     seed_i,
    input  logic [APP_AW-1:0] base_addr_i,
    input  logic [CNT_W-1:0]  num_words_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [APP_AW-1:0] first_err_addr_o
);

    localparam int unsigned BW    = $clog2(BURST_LEN + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned BYTES = DW / 8;

    tg_state_e         state, next;
    tg_mode_e          cfg_mode;
    logic [DW-1:0]     cfg_seed;
    logic [APP_AW-1:0] cfg_base;
    logic [CNT_W-1:0]  cfg_num;
    logic [CNT_W-1:0]  words_left;
    logic [BW-1:0]     beat_left;
    logic [TW-1:0]     tcnt;
    logic              in_burst, start_ok, tmo, gen_load, gen_adv;
    logic [DW-1:0]     pattern, load_seed;

    function automatic logic [BW-1:0] first_burst(input logic [CNT_W-1:0] n);
        return BW'(burst_beats(32'(n), BURST_LEN));
    endfunction

    assign in_burst = (state == WR_BURST) || (state == RD_BURST);
    assign start_ok = start_i && ((state == IDLE) || (state == DONE));
    assign tmo      = in_burst && !wb_ack_i && (tcnt == TW'(TIMEOUT - 1));

    // Read phase restarts the generator from the latched seed so it replays the written sequence.
    assign gen_load  = start_ok || ((state == WR_GAP) && (words_left == '0));
    assign load_seed = start_ok ? seed_i : cfg_seed;
    assign gen_adv   = in_burst && wb_ack_i;

    wb_tg_pattern #(
        .DW     (DW),
        .APP_AW (APP_AW)
    ) u_pattern (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .load    (gen_load),
        .advance (gen_adv),
        .mode    (cfg_mode),
        .seed    (load_seed),
        .addr    (wb_addr_o),
        .pattern (pattern)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: if (start_i) next = (num_words_i == '0) ? DONE : WR_BURST;
            WR_BURST: begin
                if (wb_ack_i && (beat_left == BW'(1))) next = WR_GAP;
                else if (tmo)                          next = DONE;
            end
            WR_GAP: next = (words_left == '0) ? RD_BURST : WR_BURST;
            RD_BURST: begin
                if (wb_ack_i && (beat_left == BW'(1))) next = RD_GAP;
                else if (tmo)                          next = DONE;
            end
            RD_GAP:  next = (words_left == '0) ? DONE : RD_BURST;
            default: next = IDLE;
        endcase
    end

    assign wb_cyc_o = in_burst;
    assign wb_stb_o = in_burst;
    assign wb_we_o  = (state == WR_BURST) || (state == WR_GAP);
    assign wb_sel_o = '1;
    assign wb_dat_o = (state == WR_BURST) ? pattern : '0;
    assign busy_o   = in_burst || (state == WR_GAP) || (state == RD_GAP);
    assign done_o   = (state == DONE);

    always_comb begin
        wb_cti_o = CTI_CLASSIC;
        if (in_burst && (BURST_LEN > 1))
            wb_cti_o = (beat_left == BW'(1)) ? CTI_EOB : CTI_INCR;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cfg_mode         <= MODE_INCR;
            cfg_seed         <= '0;
            cfg_base         <= '0;
            cfg_num          <= '0;
            wb_addr_o        <= '0;
            words_left       <= '0;
            beat_left        <= '0;
            tcnt             <= '0;
            timeout_o        <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
        end else if (start_ok) begin
            cfg_mode         <= tg_mode_e'(mode_i);
            cfg_seed         <= seed_i;
            cfg_base         <= base_addr_i;
            cfg_num          <= num_words_i;
            wb_addr_o        <= base_addr_i;
            words_left       <= num_words_i;
            beat_left        <= first_burst(num_words_i);
            tcnt             <= '0;
            timeout_o        <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
        end else begin
            case (state)
                WR_BURST, RD_BURST: begin
                    if (wb_ack_i) begin
                        wb_addr_o  <= wb_addr_o + APP_AW'(BYTES);
                        words_left <= words_left - CNT_W'(1);
                        beat_left  <= beat_left - BW'(1);
                        tcnt       <= '0;
                        if ((state == RD_BURST) && (wb_dat_i != pattern)) begin
                            if (err_cnt_o == '0) first_err_addr_o <= wb_addr_o;
                            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
                        end
                    end else if (tmo) begin
                        timeout_o <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WR_GAP: begin
                    if (words_left == '0) begin
                        wb_addr_o  <= cfg_base;
                        words_left <= cfg_num;
                        beat_left  <= first_burst(cfg_num);
                    end else begin
                        beat_left  <= first_burst(words_left);
                    end
                end
                RD_GAP:  beat_left <= first_burst(words_left);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_traffic_gen.sv
// Self-checking bench: slave memory, expected-beat model and directed scenarios.
module tb_wb_burst_traffic_gen;

    localparam int DW = 32;
    localparam int AW = 26;
    localparam int CW = 16;
    localparam int BL = 8;
    localparam int TO = 1023;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] seed = '0;
    logic [AW-1:0] base = '0;
    logic [CW-1:0] num = '0;
    logic          cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_o;
    logic [DW/8-1:0] sel;
    logic [2:0]    cti;
    logic          ack = 1'b0;
    logic [DW-1:0] dat_i = '0;
    logic          busy, done, tmo;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] first_err;

    wb_burst_traffic_gen #(
        .DW        (DW),
        .APP_AW    (AW),
        .CNT_W     (CW),
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .start_i          (start),
        .mode_i           (mode),
        .seed_i           (seed),
        .base_addr_i      (base),
        .num_words_i      (num),
        .wb_cyc_o         (cyc),
        .wb_stb_o         (stb),
        .wb_we_o          (we),
        .wb_addr_o        (addr),
        .wb_dat_o         (dat_o),
        .wb_sel_o         (sel),
        .wb_cti_o         (cti),
        .wb_ack_i         (ack),
        .wb_dat_i         (dat_i),
        .busy_o           (busy),
        .done_o           (done),
        .timeout_o        (tmo),
        .err_cnt_o        (err_cnt),
        .first_err_addr_o (first_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [2:0]    cti;
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    beat_t         expq[$];
    beat_t         obs[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int errors = 0;
    int checks = 0;
    int beat_idx = 0, rd_idx = 0, stb_wait = 0, cyc_cnt = 0;
    int corrupt_idx = -1, withhold_idx = -1;
    bit stall = 1'b0, gap_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic beat_t obs_at(input int i);
        beat_t b;
        b.addr = '1; b.we = 1'bx; b.cti = 3'bx; b.dat = 'x; b.last = 1'b0;
        if (i < obs.size()) b = obs[i];
        return b;
    endfunction

    // Word i of a region, derived directly from the pattern definitions.
    function automatic logic [DW-1:0] model_word(input int md, input logic [DW-1:0] sd,
                                                 input logic [AW-1:0] b, input int i);
        logic [DW-1:0] s;
        logic [AW-1:0] a;
        case (md)
            0: begin a = b + AW'(4 * i); return DW'(a); end
            1: begin
                s = (sd == '0) ? 32'd1 : sd;
                for (int k = 0; k < i; k++) s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
                return s;
            end
            2: return 32'h1 << (i % 32);
            default: return (i % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        endcase
    endfunction

    // Slave + monitor: decides ack on the falling edge and checks every accepted beat.
    always @(negedge clk) begin
        beat_t o, e;
        if (gap_pending) begin
            check("gap_cyc", cyc, 1'b0);
            gap_pending = 1'b0;
        end
        ack = 1'b0;
        dat_i = '0;
        if (cyc && stb) begin
            ack = 1'b1;
            if (stall && (cyc_cnt % 3 == 0)) ack = 1'b0;
            if (beat_idx == withhold_idx) ack = 1'b0;
        end
        cyc_cnt++;
        if (ack) begin
            o.addr = addr; o.we = we; o.cti = cti; o.dat = dat_o; o.last = 1'b0;
            if (we) mem[addr] = dat_o;
            else begin
                dat_i = mem.exists(addr) ? mem[addr] : '0;
                if (rd_idx == corrupt_idx) dat_i = dat_i ^ 32'h0000_FF00;
                rd_idx++;
            end
            check("beat_sel", sel, 4'hF);
            obs.push_back(o);
            beat_idx++;
            stb_wait = 0;
            if (expq.size() == 0) begin
                check("unexpected_beat_addr", o.addr, '1);
            end else begin
                e = expq.pop_front();
                check("beat_addr", o.addr, e.addr);
                check("beat_we_cti", {o.we, o.cti}, {e.we, e.cti});
                if (e.we) check("beat_wdata", o.dat, e.dat);
                gap_pending = e.last;
            end
        end else if (cyc && stb) begin
            stb_wait++;
        end
    end

    task automatic launch(input int md, input logic [DW-1:0] sd, input logic [AW-1:0] b, input int n);
        beat_t e;
        int st, len;
        expq.delete();
        obs.delete();
        beat_idx = 0; rd_idx = 0; stb_wait = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < n; i++) begin
                st     = i - (i % BL);
                len    = (n - st < BL) ? n - st : BL;
                e.addr = b + AW'(4 * i);
                e.we   = (ph == 0);
                e.last = ((i % BL) == len - 1);
                e.cti  = (BL == 1) ? 3'b000 : (e.last ? 3'b111 : 3'b010);
                e.dat  = model_word(md, sd, b, i);
                expq.push_back(e);
            end
        end
        @(negedge clk);
        mode = 2'(md); seed = sd; base = b; num = CW'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); seed = $urandom; base = AW'($urandom); num = CW'($urandom);
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int c = 0; c < budget && !done; c++) @(negedge clk);
        check(name, done, 1'b1);
    endtask

    task automatic wait_beats(input int nb);
        for (int c = 0; c < 200 && obs.size() < nb; c++) @(negedge clk);
        check("wait_beats", (obs.size() >= nb), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #1;
        check("rst_cyc_stb_we", {cyc, stb, we}, 3'b000);
        check("rst_status", {busy, done, tmo}, 3'b000);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err, 0);
        check("rst_addr_dat_cti", {addr, dat_o, cti}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Incrementing data, two full bursts
        launch(0, 0, 26'h100, 16);
        wait_done(500, "t1_done");
        check("t1_queue_left", expq.size(), 0);
        check("t1_beats", obs.size(), 32);
        check("t1_b0_addr", obs_at(0).addr, 26'h100);
        check("t1_b0_dat", obs_at(0).dat, 32'h100);
        check("t1_b6_cti", obs_at(6).cti, 3'b010);
        check("t1_b7_cti", obs_at(7).cti, 3'b111);
        check("t1_b8_cti", obs_at(8).cti, 3'b010);
        check("t1_b15_addr", obs_at(15).addr, 26'h13C);
        check("t1_b16_rd_addr", {obs_at(16).we, obs_at(16).addr}, {1'b0, 26'h100});
        check("t1_status", {busy, tmo, err_cnt}, 0);

        // LFSR, single short burst
        launch(1, 32'hACE1, 26'h0, 5);
        wait_done(500, "t2_done");
        check("t2_queue_left", expq.size(), 0);
        check("t2_b0_dat", obs_at(0).dat, 32'h0000_ACE1);
        check("t2_b1_dat", obs_at(1).dat, 32'h0001_59C3);
        check("t2_b3_dat", obs_at(3).dat, 32'h0005_670D);
        check("t2_b0_cti", obs_at(0).cti, 3'b010);
        check("t2_b4_cti", obs_at(4).cti, 3'b111);
        check("t2_err", err_cnt, 0);

        launch(1, 32'h0, 26'h80, 5);
        wait_done(500, "t2z_done");
        check("t2z_queue_left", expq.size(), 0);
        check("t2z_b0_dat", obs_at(0).dat, 32'h1);
        check("t2z_b3_dat", obs_at(3).dat, 32'hD);
        check("t2z_err", err_cnt, 0);

        // Checkerboard with word 3 corrupted on readback
        corrupt_idx = 3;
        launch(3, 0, 26'h400, 8);
        wait_done(500, "t3_done");
        corrupt_idx = -1;
        check("t3_queue_left", expq.size(), 0);
        check("t3_b0_dat", obs_at(0).dat, 32'hAAAA_AAAA);
        check("t3_b1_dat", obs_at(1).dat, 32'h5555_5555);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_first_err", first_err, 26'h40C);

        // Walking one across a short trailing burst, slave inserting wait states
        stall = 1'b1;
        launch(2, 0, 26'h1000, 10);
        wait_done(500, "t4_done");
        stall = 1'b0;
        check("t4_queue_left", expq.size(), 0);
        check("t4_b7_cti", obs_at(7).cti, 3'b111);
        check("t4_b8_cti", obs_at(8).cti, 3'b010);
        check("t4_b9", {obs_at(9).dat, obs_at(9).cti}, {32'h200, 3'b111});
        check("t4_err", err_cnt, 0);

        // Start while busy must not disturb the running test
        launch(0, 0, 26'h200, 12);
        wait_beats(2);
        @(negedge clk);
        mode = 2'd1; base = 26'h800; num = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(500, "t5_done");
        check("t5_queue_left", expq.size(), 0);
        check("t5_beats", obs.size(), 24);
        check("t5_last_addr", obs_at(23).addr, 26'h22C);

        // Ack withheld on the third beat
        withhold_idx = 2;
        launch(0, 0, 26'h40, 8);
        wait_done(2000, "t6_done");
        withhold_idx = -1;
        check("t6_stb_wait", stb_wait, TO);
        check("t6_timeout", tmo, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_cyc_stb", {cyc, stb}, 2'b00);
        check("t6_beats", obs.size(), 2);

        // Asynchronous reset in the middle of a write burst
        launch(0, 0, 26'h300, 16);
        wait_beats(3);
        #3 rst = 1'b1;
        #1;
        check("t7_rst_cyc_stb", {cyc, stb}, 2'b00);
        check("t7_rst_busy_done", {busy, done, tmo}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        expq.delete();
        rst = 1'b0;
        @(negedge clk);

        // Zero-length test
        check("t8_done_before", done, 1'b0);
        launch(0, 0, 26'h500, 0);
        check("t8_done_next_cycle", done, 1'b1);
        repeat (5) @(negedge clk);
        check("t8_no_beats", obs.size(), 0);
        check("t8_status", {busy, tmo, err_cnt}, {1'b0, 1'b0, 16'd0});

        // Clean run after reset, crossing the top of the address space
        launch(1, 32'h1234, 26'h3FF_FFF0, 8);
        wait_done(500, "t9_done");
        check("t9_queue_left", expq.size(), 0);
        check("t9_b3_addr", obs_at(3).addr, 26'h3FF_FFFC);
        check("t9_b4_addr", obs_at(4).addr, 26'h0);
        check("t9_status", {busy, tmo, err_cnt}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
